ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/ram_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first valid request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PtrW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PtrW-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [PtrW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PtrW'((32'(ptr) + i) % NUM_REQ);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with a zero-fill sweep mode and a one-stage response pipeline.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned data_depth = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        clr_start,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] NumWords = ADDR_W'(2 ** data_depth);

  arb_state_e state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [data_depth-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_gnt_q, rsp_gnt_d;
  logic                  rsp_rd_q, rsp_rd_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_done_q, clr_done_d;

  logic [NUM_REQ-1:0] arb_gnt, gnt;
  logic [PtrW-1:0]    arb_idx;
  logic               arb_any;
  logic               grant_en, accept, in_range;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = req_addr[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = req_wdata[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (PtrW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign grant_en  = (state_q == StIdle) && !clr_start && !reset;
  assign gnt       = grant_en ? arb_gnt : '0;
  assign accept    = grant_en && arb_any;
  assign sel_write = req_write[arb_idx];
  assign sel_addr  = addr_arr[arb_idx];
  assign sel_wdata = wdata_arr[arb_idx];
  // Unsigned compare: negative signed addresses appear huge and fall out of range.
  assign in_range  = sel_addr < NumWords;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    clr_done_d = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_d = StClear;
            cnt_d   = '0;
          end else if (accept) begin
            rr_ptr_d = (arb_idx == PtrW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            if (in_range) begin
              mem_read  = !sel_write;
              mem_write = sel_write;
              mem_addr  = sel_addr;
              mem_wdata = sel_wdata;
            end
          end
        end
        StClear: begin
          mem_write = 1'b1;
          mem_addr  = ADDR_W'(cnt_q);
          cnt_d     = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d    = StIdle;
            clr_done_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rsp_gnt_d  = gnt;
  assign rsp_rd_d   = accept && in_range && !sel_write;
  assign rsp_err_d  = accept && !in_range;
  assign clr_busy_d = (state_d == StClear);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      rsp_gnt_q  <= '0;
      rsp_rd_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      rsp_gnt_q  <= rsp_gnt_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_gnt_q;
  assign rsp_err   = rsp_err_q;
  // RAM returns 0 when idle, but gate anyway so writes and errors always report 0.
  assign rsp_data  = rsp_rd_q ? mem_rdata : '0;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

endmodule
